// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared encodings for the instruction sequencer
package instr_sequencer_pkg;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b01;
  localparam logic [1:0] VSEL_C = 2'b11;
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WR_REG, S_WR_IMM
  } state_e;
  typedef enum logic [2:0] {
    K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN, K_ILL
  } kind_e;
endpackage

// File: rtl/instr_dec.sv
// instr_dec: splits the instruction register into fields, sign-extends immediates, classifies the opcode
module instr_dec
  import instr_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] ir,
  output logic [2:0]       rn,
  output logic [2:0]       rd,
  output logic [2:0]       rm,
  output logic [1:0]       sh,
  output logic [1:0]       op,
  output logic [WIDTH-1:0] sximm8,
  output logic [WIDTH-1:0] sximm5,
  output kind_e            kind
);
  assign rn = ir[10:8];
  assign rd = ir[7:5];
  assign sh = ir[4:3];
  assign rm = ir[2:0];
  assign op = ir[12:11];
  assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(WIDTH-5){ir[4]}}, ir[4:0]};
  // Anything outside the MOV/ALU opcode groups, or MOV with op 01/11, is illegal.
  always_comb
    kind = (ir[15:13] == OPC_MOV) ? (op == OP_MOVI ? K_MOVI : op == OP_MOVR ? K_MOVR : K_ILL)
         : (ir[15:13] == OPC_ALU) ? (op == 2'b00 ? K_ADD : op == 2'b01 ? K_CMP : op == 2'b10 ? K_AND : K_MVN)
         : K_ILL;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: instruction register plus Moore FSM driving the datapath controls
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             s,
  input  logic [WIDTH-1:0] in,
  output logic             w,
  output logic             err,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic [1:0]       vsel,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] sximm8,
  output logic [WIDTH-1:0] sximm5
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic err_q, err_d;
  logic [2:0] rn, rd, rm;
  logic [1:0] op;
  kind_e kind;

  instr_dec #(.WIDTH(WIDTH)) u_dec (
    .ir(ir_q), .rn(rn), .rd(rd), .rm(rm), .sh(shift), .op(op),
    .sximm8(sximm8), .sximm5(sximm5), .kind(kind)
  );

  assign err = err_q;
  assign bsel = 1'b0;

  // Next state, IR/err updates and Moore output decode; everything defaults to idle.
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    err_d = err_q;
    w = 1'b0;
    readnum = 3'd0;
    writenum = 3'd0;
    write = 1'b0;
    vsel = 2'b00;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel = 1'b0;
    ALUop = ALU_ADD;
    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (load) ir_d = in;
        else if (s) begin
          state_d = S_DECODE;
          err_d = 1'b0;
        end
      end
      S_DECODE: begin
        state_d = kind == K_MOVI ? S_WR_IMM
                : (kind == K_ADD || kind == K_CMP || kind == K_AND) ? S_GET_A
                : (kind == K_MOVR || kind == K_MVN) ? S_GET_B
                : S_WAIT;
        err_d = kind == K_ILL;
      end
      S_GET_A: begin
        readnum = rn;
        loada = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        asel = kind == K_MOVR || kind == K_MVN;
        ALUop = kind == K_MOVR ? ALU_ADD : op;
        loadc = 1'b1;
        loads = kind != K_MOVR;
        state_d = kind == K_CMP ? S_WAIT : S_WR_REG;
      end
      S_WR_REG: begin
        vsel = VSEL_C;
        writenum = rd;
        write = 1'b1;
        state_d = S_WAIT;
      end
      S_WR_IMM: begin
        vsel = VSEL_IMM8;
        writenum = rn;
        write = 1'b1;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // State, IR and sticky error registers; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_WAIT;
      ir_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      err_q <= err_d;
    end
endmodule
